uart_byte_receiver: RTL and testbench

//  Serial 8N1 UART receiver. Sits directly upstream of the instruction-memory loader.

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_byte_receiver_if.sv | 27 ++
 rtl/sync_2ff.sv | 24 ++
 rtl/uart_byte_receiver.sv | 132 +++++++++++++
 tb/tb_uart_byte_receiver.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART byte receiver.
// Bit timing default assumes a 100 MHz clock at 115200 baud.
package uart_pkg;

  localparam int UART_CLK_PER_BIT = 868;
  localparam int UART_DATA_BITS = 8;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_t;

endpackage

// File: rtl/uart_byte_receiver_if.sv
// Serial line in, framed bytes and status strobes out.
// The slave side is the receiver; the master side is the line/host.
interface uart_byte_receiver_if;

  logic       rxd;
  logic [7:0] rdata;
  logic       rdata_ready;
  logic       ferr;
  logic       busy;

  modport slave (
    input  rxd,
    output rdata,
    output rdata_ready,
    output ferr,
    output busy
  );

  modport master (
    output rxd,
    input  rdata,
    input  rdata_ready,
    input  ferr,
    input  busy
  );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for an asynchronous single-bit input.
// The reset value sets what downstream sees before real data arrives.
module sync_2ff #(
  parameter bit RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_byte_receiver.sv
// 8N1 UART receiver: mid-bit sampling, LSB first, one-cycle strobes.
// Returns to IDLE at mid stop bit so back-to-back frames are caught.
module uart_byte_receiver
  import uart_pkg::*;
#(
  parameter int CLK_PER_BIT = UART_CLK_PER_BIT
) (
  input  logic CLK,
  input  logic reset,
  uart_byte_receiver_if.slave rx
);

  localparam int CW = $clog2(CLK_PER_BIT) + 1;
  localparam int BW = $clog2(UART_DATA_BITS);
  localparam logic [CW-1:0] HALF_LAST =
    CW'(CLK_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_LAST =
    CW'(CLK_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BIT =
    BW'(UART_DATA_BITS - 1);

  rx_state_t state;
  rx_state_t state_n;

  logic                      rx_s;
  logic                      tick;
  logic [CW-1:0]             cyc;
  logic [BW-1:0]             bit_idx;
  logic [UART_DATA_BITS-1:0] shift;
  logic [UART_DATA_BITS-1:0] rdata_q;
  logic                      ready_q;
  logic                      ferr_q;
  logic                      armed;
  logic [1:0]                warm;
  logic                      stop_tick;

  sync_2ff #(
    .RST_VAL(1'b1)
  ) u_sync (
    .clk  (CLK),
    .reset(reset),
    .d    (rx.rxd),
    .q    (rx_s)
  );

  always_ff @(posedge CLK) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    tick    = 1'b0;
    unique case (state)
      IDLE: begin
        if (armed && !rx_s) begin
          state_n = START;
        end
      end
      START: begin
        if (cyc == HALF_LAST) begin
          tick    = 1'b1;
          state_n = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cyc == FULL_LAST) begin
          tick = 1'b1;
          if (bit_idx == LAST_BIT) begin
            state_n = STOP;
          end
        end
      end
      STOP: begin
        if (cyc == FULL_LAST) begin
          tick    = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign stop_tick = (state == STOP) && tick;

  always_ff @(posedge CLK) begin
    if (reset) begin
      cyc     <= '0;
      bit_idx <= '0;
      shift   <= '0;
      rdata_q <= '0;
      ready_q <= 1'b0;
      ferr_q  <= 1'b0;
      armed   <= 1'b0;
      warm    <= '0;
    end else begin
      // Every sample point ends a bit period, so the count restarts there.
      if (tick || state == IDLE) begin
        cyc <= '0;
      end else begin
        cyc <= cyc + CW'(1);
      end
      if (state == START) begin
        bit_idx <= '0;
      end else if (state == DATA && tick) begin
        bit_idx <= bit_idx + BW'(1);
      end
      if (state == DATA && tick) begin
        shift <= {rx_s, shift[UART_DATA_BITS-1:1]};
      end
      if (stop_tick && rx_s) begin
        rdata_q <= shift;
      end
      ready_q <= stop_tick && rx_s;
      ferr_q  <= stop_tick && !rx_s;
      // Synchronizer reset ones must not arm us; wait until real data.
      warm <= {warm[0], 1'b1};
      if (warm[1] && rx_s) begin
        armed <= 1'b1;
      end
    end
  end

  assign rx.rdata       = rdata_q;
  assign rx.rdata_ready = ready_q;
  assign rx.ferr        = ferr_q;
  assign rx.busy        = (state != IDLE);

endmodule

// File: tb/tb_uart_byte_receiver.sv
// Bench for uart_byte_receiver: directed cases plus random frames,
// checked against a frame-level expectation queue every cycle.
module tb_uart_byte_receiver;

  localparam int CPB = 16;
  localparam int LAT = 2 + CPB / 2 + 9 * CPB;

  typedef struct {
    bit         err;
    logic [7:0] data;
    int         t0;
  } ev_t;

  logic clk = 1'b0;
  logic reset = 1'b1;

  uart_byte_receiver_if bus ();

  uart_byte_receiver #(
    .CLK_PER_BIT(CPB)
  ) dut (
    .CLK  (clk),
    .reset(reset),
    .rx   (bus)
  );

  always #5 clk = ~clk;

  ev_t        expq[$];
  logic [7:0] got[$];
  int         n_tests = 0;
  int         n_fail = 0;
  int         cyc_n = 0;
  int         n_strobe = 0;
  int         n_ferr = 0;
  logic [7:0] model_rdata = 8'h00;
  bit         rst_seen = 1'b1;
  bit         prev_rr = 1'b0;
  bit         prev_fe = 1'b0;

  task automatic check(input bit ok, input string name,
                       input int act, input int exp);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    cyc_n++;
    rst_seen = reset;
  end

  always @(negedge clk) begin
    ev_t e;
    int  lat;
    if (rst_seen) begin
      check(bus.rdata == 8'h00, "reset_rdata",
            int'(bus.rdata), 0);
      check(!bus.rdata_ready && !bus.ferr && !bus.busy,
            "reset_flags",
            int'({bus.rdata_ready, bus.ferr, bus.busy}), 0);
      model_rdata = 8'h00;
      expq.delete();
    end else begin
      if (bus.rdata_ready && bus.ferr) begin
        check(0, "both_strobes", 1, 0);
      end
      if (bus.rdata_ready) begin
        n_strobe++;
        got.push_back(bus.rdata);
        check(!prev_rr, "ready_twice", 1, 0);
        if (expq.size() == 0) begin
          check(0, "spurious_ready", int'(bus.rdata), 0);
        end else begin
          e = expq.pop_front();
          lat = cyc_n - e.t0;
          check(!e.err, "ready_not_ferr", 1, int'(e.err));
          check(bus.rdata == e.data, "byte",
                int'(bus.rdata), int'(e.data));
          check(lat >= LAT - 2 && lat <= LAT + 2, "latency",
                lat, LAT);
          model_rdata = e.data;
        end
      end
      if (bus.ferr) begin
        n_ferr++;
        check(!prev_fe, "ferr_twice", 1, 0);
        if (expq.size() == 0) begin
          check(0, "spurious_ferr", 1, 0);
        end else begin
          e = expq.pop_front();
          lat = cyc_n - e.t0;
          check(e.err, "ferr_not_ready", 0, 1);
          check(lat >= LAT - 2 && lat <= LAT + 2, "ferr_latency",
                lat, LAT);
        end
      end
      check(bus.rdata == model_rdata, "rdata_hold",
            int'(bus.rdata), int'(model_rdata));
    end
    prev_rr = bus.rdata_ready;
    prev_fe = bus.ferr;
  end

  task automatic bit_out(input logic v);
    bus.rxd = v;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bus.rxd = 1'b1;
    if (n > 0) begin
      repeat (n) @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] b, input bit stop_ok,
                      input bit chk_busy);
    ev_t e;
    e.err  = !stop_ok;
    e.data = b;
    e.t0   = cyc_n;
    expq.push_back(e);
    bit_out(1'b0);
    if (chk_busy) begin
      check(bus.busy == 1'b1, "busy_mid", int'(bus.busy), 1);
    end
    for (int i = 0; i < 8; i++) begin
      bit_out(b[i]);
    end
    bit_out(stop_ok);
  endtask

  task automatic wait_done(input string name);
    int k = 0;
    while ((expq.size() != 0 || bus.busy) && k < 600) begin
      @(posedge clk);
      #1;
      k++;
    end
    check(k < 600, name, k, 600);
    check(bus.busy == 1'b0, "busy_after", int'(bus.busy), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] seq[8];
    int s0;
    int f0;
    int n_ok;
    int n_bad;
    logic [7:0] b;
    bit ok;

    seq = '{8'h04, 8'h10, 8'hC2, 8'h00,
            8'h58, 8'h04, 8'h65, 8'h00};
    bus.rxd = 1'b1;
    reset = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b0;
    idle(40);

    got.delete();
    send(8'h04, 1'b1, 1'b1);
    idle(4);
    wait_done("t1_done");
    check(got.size() == 1, "t1_count", got.size(), 1);
    check(bus.rdata == 8'h04, "t1_rdata", int'(bus.rdata), 4);
    check(n_ferr == 0, "t1_ferr", n_ferr, 0);

    got.delete();
    for (int i = 0; i < 8; i++) begin
      send(seq[i], 1'b1, 1'b0);
    end
    idle(4);
    wait_done("t2_done");
    check(got.size() == 8, "t2_count", got.size(), 8);
    for (int i = 0; i < 8 && i < got.size(); i++) begin
      check(got[i] == seq[i], "t2_order",
            int'(got[i]), int'(seq[i]));
    end

    s0 = n_strobe;
    f0 = n_ferr;
    bus.rxd = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    idle(40);
    check(bus.busy == 1'b0, "t3_idle", int'(bus.busy), 0);
    check(n_strobe == s0 && n_ferr == f0, "t3_no_strobe",
          n_strobe - s0 + n_ferr - f0, 0);
    check(bus.rdata == 8'h00, "t3_rdata", int'(bus.rdata), 0);

    s0 = n_strobe;
    f0 = n_ferr;
    send(8'hA5, 1'b0, 1'b0);
    idle(2 * CPB);
    check(n_ferr - f0 == 1, "t4_ferr", n_ferr - f0, 1);
    check(bus.rdata == 8'h00, "t4_keep", int'(bus.rdata), 0);
    send(8'h3C, 1'b1, 1'b0);
    idle(4);
    wait_done("t4_done");
    check(bus.rdata == 8'h3C, "t4_rdata", int'(bus.rdata), 8'h3C);
    check(n_strobe - s0 == 1, "t4_count", n_strobe - s0, 1);

    s0 = n_strobe;
    bit_out(1'b0);
    for (int i = 0; i < 3; i++) begin
      bit_out(1'b0);
    end
    bus.rxd = 1'b0;
    repeat (CPB / 2) @(posedge clk);
    #1;
    reset = 1'b1;
    bus.rxd = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    idle(3 * CPB);
    check(n_strobe == s0, "t5_abort", n_strobe - s0, 0);
    send(8'h58, 1'b1, 1'b0);
    idle(4);
    wait_done("t5_done");
    check(n_strobe - s0 == 1, "t5_count", n_strobe - s0, 1);
    check(bus.rdata == 8'h58, "t5_rdata", int'(bus.rdata), 8'h58);

    s0 = n_strobe;
    f0 = n_ferr;
    bus.rxd = 1'b0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    check(bus.busy == 1'b0, "t6_ignored", int'(bus.busy), 0);
    idle(2 * CPB);
    check(n_strobe == s0 && n_ferr == f0, "t6_quiet",
          n_strobe - s0 + n_ferr - f0, 0);
    send(8'h65, 1'b1, 1'b0);
    idle(4);
    wait_done("t6_done");
    check(n_strobe - s0 == 1, "t6_count", n_strobe - s0, 1);
    check(bus.rdata == 8'h65, "t6_rdata", int'(bus.rdata), 8'h65);

    s0 = n_strobe;
    f0 = n_ferr;
    n_ok = 0;
    n_bad = 0;
    for (int i = 0; i < 40; i++) begin
      b  = 8'($urandom);
      ok = ($urandom_range(0, 4) != 0);
      send(b, ok, 1'b0);
      if (ok) begin
        n_ok++;
        idle($urandom_range(0, 20));
      end else begin
        n_bad++;
        idle(CPB + $urandom_range(0, 20));
      end
    end
    idle(4);
    wait_done("rand_done");
    check(n_strobe - s0 == n_ok, "rand_ok", n_strobe - s0, n_ok);
    check(n_ferr - f0 == n_bad, "rand_bad", n_ferr - f0, n_bad);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
